// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Control shadow of an in-order pipeline. Tracks a per-stage tag
//   (valid, rd, wen, load, rs1/rs2 + use flags) and derives valids, the
//   front-end stall, load-use bubbles, redirect squashes, operand bypass
//   selects for the read stage and the register-file commit strobe.
//   Stage 0 is fetch, stage STAGES-1 is writeback.
// Ports
//   clk, rst               clock (rising), asynchronous active-high reset
//   f_*                    stage-0 instruction tag
//   redir_valid/_stage     redirect resolved this cycle and its stage index
//   stage_valid            per-stage valid bits
//   stall_f                hold stages 0..RD_STAGE
//   fwd_sel_a/_b           bypass select: 0 = regfile, k = stage RD_STAGE+k
//   commit_wen/_rd         register-file write strobe and address

// Per-stage producer compare against the operand-read stage sources.
module phc_stage_match (
  input  logic       valid,
  input  logic       wen,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use1,
  input  logic       use2,
  output logic       hit1,
  output logic       hit2
);
  logic wr_ok;
  // x0 is never a real producer
  assign wr_ok = valid && wen && (rd != 5'd0);
  assign hit1  = wr_ok && use1 && (rd == rs1);
  assign hit2  = wr_ok && use2 && (rd == rs2);
endmodule

module pipeline_hazard_ctrl #(
  parameter int STAGES     = 6,
  parameter int RD_STAGE   = 2,
  parameter int LOAD_STAGE = 4,
  parameter int SEL_W      = $clog2(STAGES - RD_STAGE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      f_valid,
  input  logic [4:0]                f_rs1,
  input  logic [4:0]                f_rs2,
  input  logic [4:0]                f_rd,
  input  logic                      f_use_rs1,
  input  logic                      f_use_rs2,
  input  logic                      f_wen,
  input  logic                      f_load,
  input  logic                      redir_valid,
  input  logic [$clog2(STAGES)-1:0] redir_stage,
  output logic [STAGES-1:0]         stage_valid,
  output logic                      stall_f,
  output logic [SEL_W-1:0]          fwd_sel_a,
  output logic [SEL_W-1:0]          fwd_sel_b,
  output logic                      commit_wen,
  output logic [4:0]                commit_rd
);
  localparam int RW = $clog2(STAGES);
  localparam int NB = STAGES - RD_STAGE - 1;     // producers younger than W..X
  localparam int NH = LOAD_STAGE - RD_STAGE - 1; // stages where load data is not ready

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       wen;
    logic       load;
    logic       use1;
    logic       use2;
  } tag_t;

  tag_t [STAGES-1:0] tag_q, tag_d;
  tag_t              f_tag, d2;
  logic [NB-1:0]     hit1, hit2;
  logic              hz, kill_rd;
  int                redir_i;
  logic              unused_tag_bits;

  assign f_tag = '{valid: f_valid, rd: f_rd, rs1: f_rs1, rs2: f_rs2,
                   wen: f_wen, load: f_load, use1: f_use_rs1, use2: f_use_rs2};
  assign d2      = tag_q[RD_STAGE];
  assign redir_i = 32'(redir_stage);

  // hit*[k] refers to stage RD_STAGE+1+k
  for (genvar k = 0; k < NB; k++) begin : g_match
    phc_stage_match u_match (
      .valid (tag_q[RD_STAGE+1+k].valid),
      .wen   (tag_q[RD_STAGE+1+k].wen),
      .rd    (tag_q[RD_STAGE+1+k].rd),
      .rs1   (d2.rs1),
      .rs2   (d2.rs2),
      .use1  (d2.use1),
      .use2  (d2.use2),
      .hit1  (hit1[k]),
      .hit2  (hit2[k])
    );
  end

  always_comb begin
    hz = 1'b0;
    for (int k = 0; k < NH; k++)
      if (tag_q[RD_STAGE+1+k].load && (hit1[k] || hit2[k])) hz = 1'b1;
    hz = hz && d2.valid;
  end

  // A squash past the read stage removes the consumer, so the stall is moot.
  assign kill_rd = redir_valid && (redir_stage > RW'(RD_STAGE));
  assign stall_f = hz && !kill_rd;

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    for (int k = NB - 1; k >= 0; k--) begin
      if (hit1[k]) fwd_sel_a = SEL_W'(k + 1);
      if (hit2[k]) fwd_sel_b = SEL_W'(k + 1);
    end
  end

  always_comb begin
    for (int i = 0; i < STAGES; i++) stage_valid[i] = tag_q[i].valid;
  end

  assign commit_wen = tag_q[STAGES-1].valid && tag_q[STAGES-1].wen &&
                      (tag_q[STAGES-1].rd != 5'd0);
  assign commit_rd  = tag_q[STAGES-1].rd;

  always_comb begin
    tag_d = tag_q;
    if (stall_f) begin
      // front end holds, a bubble enters the stage after the read stage
      tag_d[RD_STAGE+1] = '0;
      for (int i = RD_STAGE + 2; i < STAGES; i++) tag_d[i] = tag_q[i-1];
      // held entries younger than the redirecting stage are dropped in place
      if (redir_valid)
        for (int i = 0; i <= RD_STAGE; i++)
          if (i < redir_i) tag_d[i].valid = 1'b0;
    end else begin
      tag_d[0] = f_tag;
      for (int i = 1; i < STAGES; i++) tag_d[i] = tag_q[i-1];
      // entries landing at or before the redirecting stage are wrong-path
      if (redir_valid)
        for (int i = 1; i < STAGES; i++)
          if (i <= redir_i) tag_d[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tag_q <= '0;
    else     tag_q <= tag_d;
  end

  // source fields of the last stage are carried but never consulted
  assign unused_tag_bits = ^{tag_q[STAGES-1].rs1, tag_q[STAGES-1].rs2,
                             tag_q[STAGES-1].load, tag_q[STAGES-1].use1,
                             tag_q[STAGES-1].use2};
endmodule
